gcd_controller: RTL
===================

GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL expose: rst  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: start  input  1  request one GCD computation; sampled only in IDLE.
REQ-004 The block SHALL expose: x_gt_y, x_eq_y, x_ls_y  input  1 each  datapath comparator flags for the current X/Y register contents.
REQ-005 The block SHALL expose: x_sel, y_sel  output  1 each  datapath mux select; 0 = external operand, 1 = ALU result.
REQ-006 The block SHALL expose: x_en, y_en  output  1 each  X/Y register load enables.
REQ-007 The block SHALL expose: x_op, y_op  output  2 each  ALU op; 00 = pass own register, 01 = own minus other, 10 = pass external operand, 11 = unused, never driven.
REQ-008 The block SHALL expose: done_en  output  1  result register load enable.
REQ-009 The block SHALL expose: busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL expose: done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL expose: error  output  1  qualifies done; high with done when no valid result was stored.
REQ-012 The block SHALL expose: steps  output  8  count of subtraction steps taken in the current or most recent computation.

Function
REQ-013 All outputs SHALL be registered Moore outputs decoded from a state register; state set = IDLE, LOAD, COMPARE, SUB_X, SUB_Y, STORE, DONE, ERR.
REQ-014 In IDLE, start=1 SHALL move to LOAD; start=0 SHALL stay in IDLE; start in any other state SHALL be ignored and not queued.
REQ-015 LOAD SHALL drive x_sel=y_sel=0, x_en=y_en=1, x_op=y_op=00, clear steps to 0, and go to COMPARE.
REQ-016 COMPARE SHALL drive all enables 0 and branch on flags: exactly x_eq_y -> STORE; exactly x_gt_y -> SUB_X; exactly x_ls_y -> SUB_Y.
REQ-017 COMPARE with zero or more than one flag set SHALL go to ERR.
REQ-018 COMPARE with x_eq_y=0 and steps=255 SHALL go to ERR; this takes priority over SUB_X/SUB_Y.
REQ-019 SUB_X SHALL drive x_sel=1, x_op=01, x_en=1, y_en=0, increment steps by 1, and return to COMPARE.
REQ-020 SUB_Y SHALL drive y_sel=1, y_op=01, y_en=1, x_en=0, increment steps by 1, and return to COMPARE.
REQ-021 The steps counter SHALL never wrap: REQ-018 guarantees no increment from 255.
REQ-022 STORE SHALL drive done_en=1 for exactly one cycle and go to DONE.
REQ-023 DONE SHALL drive done=1, error=0 for one cycle and return to IDLE.
REQ-024 ERR SHALL drive done=1, error=1 for one cycle with done_en=0, so the result register keeps its previous value, and SHALL return to IDLE.
REQ-025 Latency SHALL be: done high in the (4+2k)th cycle after the edge that samples start, where k = subtraction steps.
REQ-026 A new start SHALL be accepted in the cycle after DONE/ERR, giving back-to-back operation with one IDLE cycle.
REQ-027 A zero operand SHALL produce no special handling; it ends in ERR by step-limit timeout.
REQ-028 steps SHALL hold its final value in IDLE until the next LOAD.

Reset
REQ-029 rst=0 SHALL force state IDLE immediately, regardless of clk.
REQ-030 While rst=0, all outputs SHALL be 0, including steps.
REQ-031 Reset mid-computation SHALL abandon the operation with no done or error pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst returns high.

Verification
REQ-033 Bench SHALL cover: x=12, y=18, start pulse -> SUB_Y then SUB_X; done=1, error=0 eight cycles after start; done_en pulsed once; steps=2.
REQ-034 Bench SHALL cover: x=y=7 -> done four cycles after start; steps=0; no SUB state entered.
REQ-035 Bench SHALL cover: x=255, y=1 -> steps=254; done=1, error=0; latency 512 cycles.
REQ-036 Bench SHALL cover: x=0, y=5 -> 255 SUB_Y steps, then ERR; done=1, error=1, done_en never asserted; steps=255.
REQ-037 Bench SHALL cover: illegal flags (x_gt_y=x_ls_y=1) in COMPARE -> ERR next cycle; done=error=1.
REQ-038 Bench SHALL cover: rst asserted in SUB_X -> all outputs 0 asynchronously; start held high during busy is ignored; start after reset release is accepted on the first edge.

Source files
------------

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a subtract-and-compare GCD datapath.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   start                    request one computation (honoured only in IDLE)
//   x_gt_y, x_eq_y, x_ls_y   comparator flags for the current X/Y contents
//   x_sel, y_sel             mux select: 0 = external operand, 1 = ALU result
//   x_en, y_en               X/Y register load enables
//   x_op, y_op               ALU op: 00 pass own, 01 own minus other, 10 pass ext
//   done_en                  result register load enable
//   busy                     high in every state except IDLE
//   done                     one-cycle completion pulse
//   error                    qualifies done: no valid result was stored
//   steps                    subtraction steps in current / most recent run
//
// All control outputs are a pure decode of the state register, so each one
// changes only at a clock edge (or at reset).
module gcd_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       x_gt_y,
  input  logic       x_eq_y,
  input  logic       x_ls_y,
  output logic       x_sel,
  output logic       y_sel,
  output logic       x_en,
  output logic       y_en,
  output logic [1:0] x_op,
  output logic [1:0] y_op,
  output logic       done_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] steps
);

  typedef enum logic [2:0] {
    IDLE, LOAD, COMPARE, SUB_X, SUB_Y, STORE, DONE, ERR
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;

  state_t     state, next_state;
  logic [7:0] steps_q;
  logic       at_limit;

  assign at_limit = (steps_q == 8'hFF);
  assign steps    = steps_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Cleared in LOAD, bumped once per SUB state. The step limit in COMPARE
  // stops the run before a SUB state can be entered at 255, so no wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   steps_q <= '0;
    else if (state == LOAD)                     steps_q <= '0;
    else if (state == SUB_X || state == SUB_Y) steps_q <= steps_q + 8'd1;
  end

  always_comb begin
    next_state = state;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    x_en       = 1'b0;
    y_en       = 1'b0;
    x_op       = OP_PASS;
    y_op       = OP_PASS;
    done_en    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = LOAD;
      end
      LOAD: begin
        x_en       = 1'b1;
        y_en       = 1'b1;
        next_state = COMPARE;
      end
      COMPARE: begin
        // Only a one-hot flag set is meaningful; anything else is a
        // datapath fault. Equality wins over the step limit.
        case ({x_gt_y, x_eq_y, x_ls_y})
          3'b010:  next_state = STORE;
          3'b100:  next_state = at_limit ? ERR : SUB_X;
          3'b001:  next_state = at_limit ? ERR : SUB_Y;
          default: next_state = ERR;
        endcase
      end
      SUB_X: begin
        x_sel      = 1'b1;
        x_op       = OP_SUB;
        x_en       = 1'b1;
        next_state = COMPARE;
      end
      SUB_Y: begin
        y_sel      = 1'b1;
        y_op       = OP_SUB;
        y_en       = 1'b1;
        next_state = COMPARE;
      end
      STORE: begin
        done_en    = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        error      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
